// File: rtl/vx_issue_sched_pkg.sv
// ----------------------------------------------------------------------------
// vx_issue_sched_pkg
// Shared definitions for the issue stage and its neighbours (decode, dispatch,
// commit). Holds the execute-unit encodings, their default widths, the issue
// FSM state type and the default performance counter width.
// ----------------------------------------------------------------------------
package vx_issue_sched_pkg;

  // ex_type field width and number of real execute units
  localparam int VX_EX_BITS = 3;
  localparam int VX_NUM_EX  = 5;

  // Execute-unit encodings carried in ex_type
  localparam logic [VX_EX_BITS-1:0] EX_ALU = 3'd0;
  localparam logic [VX_EX_BITS-1:0] EX_LSU = 3'd1;
  localparam logic [VX_EX_BITS-1:0] EX_CSR = 3'd2;
  localparam logic [VX_EX_BITS-1:0] EX_FPU = 3'd3;
  localparam logic [VX_EX_BITS-1:0] EX_GPU = 3'd4;

  // Default width of the issue/stall performance counters
  localparam int VX_PERF_W = 32;

  // Issue FSM: IDLE arbitrates freely, LOCKED holds a stalled winner
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } issue_state_e;

endpackage

// File: rtl/vx_issue_sched_rr_pick.sv
// ----------------------------------------------------------------------------
// vx_rr_pick
// Combinational rotate-priority picker. Returns the first asserted request
// found scanning i_ptr, i_ptr+1, ... wrapping modulo N. N must be a power of
// two (>= 2) so the index arithmetic wraps naturally.
//
// Ports:
//   i_req         N-bit request vector
//   i_ptr         index holding highest priority this cycle
//   o_grant_idx   index of the winning request (0 when none)
//   o_grant_valid at least one request asserted
// ----------------------------------------------------------------------------
module vx_rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down to i_ptr itself, so the request
  // closest to the pointer is the last one written and therefore wins.
  always_comb begin
    o_grant_idx   = '0;
    o_grant_valid = |i_req;
    w_idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = i_ptr + IDX_W'(k);
      if (i_req[w_idx]) begin
        o_grant_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/vx_issue_sched.sv
// ----------------------------------------------------------------------------
// vx_issue_sched
// Per-cycle warp issue scheduler in front of dispatch. A warp is eligible when
// its ibuffer head is valid, its scoreboard is clear and its target execute
// unit can accept (ex_type values past the last unit are NOPs and always
// accepted). Eligible warps are arbitrated round-robin; the winner is
// presented on a valid/ready interface with zero-cycle latency. A winner that
// is stalled by dispatch stays locked (same wid and ex_type) until it fires.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_head_valid     per-warp ibuffer head holds an instruction
//   i_head_ex_type   per-warp ex_type, warp w at [w*EX_BITS +: EX_BITS]
//   i_sb_ready       per-warp scoreboard clear
//   i_unit_ready     per-unit dispatch buffer can accept
//   o_head_pop       one-hot pop of the issued warp's ibuffer head
//   o_issue_valid    instruction presented to dispatch
//   o_issue_wid      selected warp id
//   o_issue_ex_type  ex_type of the selected instruction
//   i_issue_ready    dispatch accepts
//   o_perf_issued    instructions issued since reset
//   o_perf_stalls    cycles with a valid head but no issue
// ----------------------------------------------------------------------------
module vx_issue_sched
  import vx_issue_sched_pkg::*;
#(
  parameter  int NUM_WARPS = 4,
  parameter  int EX_BITS   = VX_EX_BITS,
  parameter  int NUM_EX    = VX_NUM_EX,
  parameter  int PERF_W    = VX_PERF_W,
  localparam int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WARPS-1:0]         i_head_valid,
  input  logic [NUM_WARPS*EX_BITS-1:0] i_head_ex_type,
  input  logic [NUM_WARPS-1:0]         i_sb_ready,
  input  logic [NUM_EX-1:0]            i_unit_ready,
  output logic [NUM_WARPS-1:0]         o_head_pop,
  output logic                         o_issue_valid,
  output logic [WID_W-1:0]             o_issue_wid,
  output logic [EX_BITS-1:0]           o_issue_ex_type,
  input  logic                         i_issue_ready,
  output logic [PERF_W-1:0]            o_perf_issued,
  output logic [PERF_W-1:0]            o_perf_stalls
);

  localparam int EX_SPAN = 1 << EX_BITS;

  issue_state_e           r_state;
  issue_state_e           w_state_nxt;
  logic [WID_W-1:0]       r_rr_ptr;
  logic [WID_W-1:0]       w_rr_nxt;
  logic [WID_W-1:0]       r_lock_wid;
  logic [WID_W-1:0]       w_lock_nxt;
  logic [PERF_W-1:0]      r_perf_issued;
  logic [PERF_W-1:0]      r_perf_stalls;

  logic [EX_SPAN-1:0]     w_unit_ext;
  logic [NUM_WARPS-1:0]   w_eligible;
  logic [WID_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;
  logic [WID_W-1:0]       w_sel;
  logic                   w_valid;
  logic                   w_fire;

  // Widen unit_ready over the whole ex_type code space; codes without a real
  // unit are NOPs and read as always-ready.
  always_comb begin
    w_unit_ext               = '1;
    w_unit_ext[NUM_EX-1:0]   = i_unit_ready;
  end

  always_comb begin
    w_eligible = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_eligible[w] = i_head_valid[w] & i_sb_ready[w]
                    & w_unit_ext[i_head_ex_type[w*EX_BITS +: EX_BITS]];
    end
  end

  vx_rr_pick #(
    .N (NUM_WARPS)
  ) u_pick (
    .i_req         (w_eligible),
    .i_ptr         (r_rr_ptr),
    .o_grant_idx   (w_pick_idx),
    .o_grant_valid (w_pick_valid)
  );

  // Output side of the FSM. A locked winner is presented regardless of the
  // other warps. Outputs are forced to zero while reset is held, and wid /
  // ex_type are zeroed when nothing is presented so they never reflect the
  // head of a warp that was not selected.
  always_comb begin
    w_sel           = (r_state == LOCKED) ? r_lock_wid : w_pick_idx;
    w_valid         = ~reset & ((r_state == LOCKED) | w_pick_valid);
    w_fire          = w_valid & i_issue_ready;
    o_issue_valid   = w_valid;
    o_issue_wid     = '0;
    o_issue_ex_type = '0;
    o_head_pop      = '0;
    if (w_valid) begin
      o_issue_wid     = w_sel;
      o_issue_ex_type = i_head_ex_type[w_sel*EX_BITS +: EX_BITS];
    end
    if (w_fire) begin
      o_head_pop[w_sel] = 1'b1;
    end
  end

  // Next-state side of the FSM. Firing moves the round-robin pointer just
  // past the issued warp; a presented-but-refused winner becomes locked.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_wid;
    case (r_state)
      IDLE: begin
        if (w_fire) begin
          w_rr_nxt = w_pick_idx + WID_W'(1);
        end else if (w_valid) begin
          w_lock_nxt  = w_pick_idx;
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_fire) begin
          w_rr_nxt    = r_lock_wid + WID_W'(1);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, pointer and lock registers; reset discards any lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_lock_wid <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_lock_wid <= w_lock_nxt;
    end
  end

  // Performance counters, wrapping modulo 2^PERF_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_fire) begin
        r_perf_issued <= r_perf_issued + PERF_W'(1);
      end
      if ((|i_head_valid) && !w_fire) begin
        r_perf_stalls <= r_perf_stalls + PERF_W'(1);
      end
    end
  end

  assign o_perf_issued = r_perf_issued;
  assign o_perf_stalls = r_perf_stalls;

  // Upstream must keep a locked warp's head valid until it issues.
  a_lock_head_held: assert property (@(posedge clk) disable iff (reset)
    (r_state == LOCKED) |-> i_head_valid[r_lock_wid]);

  // A refused instruction stays put until dispatch takes it.
  a_issue_stable: assert property (@(posedge clk) disable iff (reset)
    (o_issue_valid && !i_issue_ready) |=>
      (o_issue_valid && $stable(o_issue_wid) && $stable(o_issue_ex_type)));

endmodule

// File: tb/tb_vx_issue_sched.sv
// ----------------------------------------------------------------------------
// tb_vx_issue_sched
// Self-checking bench for vx_issue_sched: directed scenarios plus a randomized
// run checked against a behavioural round-robin/lock model.
// ----------------------------------------------------------------------------
module tb_vx_issue_sched;
  import vx_issue_sched_pkg::*;

  localparam int NW  = 4;
  localparam int EXB = 3;
  localparam int NEX = 5;
  localparam int PW  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NW-1:0]     hv;
  logic [NW*EXB-1:0] ext;
  logic [NW-1:0]     sb;
  logic [NEX-1:0]    ur;
  logic              ir;
  logic [NW-1:0]     o_head_pop;
  logic              o_issue_valid;
  logic [1:0]        o_issue_wid;
  logic [EXB-1:0]    o_issue_ex_type;
  logic [PW-1:0]     o_perf_issued;
  logic [PW-1:0]     o_perf_stalls;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  int          m_rr     = 0;
  int          m_lock   = 0;
  bit          m_locked = 0;
  logic [31:0] m_issued = '0;
  logic [31:0] m_stalls = '0;

  vx_issue_sched #(
    .NUM_WARPS (NW),
    .EX_BITS   (EXB),
    .NUM_EX    (NEX),
    .PERF_W    (PW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_head_valid    (hv),
    .i_head_ex_type  (ext),
    .i_sb_ready      (sb),
    .i_unit_ready    (ur),
    .o_head_pop      (o_head_pop),
    .o_issue_valid   (o_issue_valid),
    .o_issue_wid     (o_issue_wid),
    .o_issue_ex_type (o_issue_ex_type),
    .i_issue_ready   (ir),
    .o_perf_issued   (o_perf_issued),
    .o_perf_stalls   (o_perf_stalls)
  );

  always #5 clk = ~clk;

  function automatic bit m_elig(int w);
    int ex;
    ex = int'(ext[w*EXB +: EXB]);
    return hv[w] && sb[w] && (ex >= NEX || ur[ex]);
  endfunction

  // Winner under the scheduling rules, -1 when nothing is presented
  function automatic int m_winner();
    if (m_locked) return m_lock;
    for (int k = 0; k < NW; k++) begin
      if (m_elig((m_rr + k) % NW)) return (m_rr + k) % NW;
    end
    return -1;
  endfunction

  // Model advances on each rising edge from the driven inputs only
  always @(posedge clk) begin
    int win;
    bit fire;
    if (reset) begin
      m_rr = 0; m_lock = 0; m_locked = 0; m_issued = '0; m_stalls = '0;
    end else begin
      win  = m_winner();
      fire = (win >= 0) && ir;
      if (fire) begin
        m_issued = m_issued + 1;
        m_rr     = (win + 1) % NW;
        m_locked = 0;
      end else if (win >= 0) begin
        m_locked = 1;
        m_lock   = win;
      end
      if ((|hv) && !fire) m_stalls = m_stalls + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; hv = '0; sb = '0; ur = '0; ext = '0; ir = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; hv = '1; sb = '1; ur = '1; ext = '0; ir = 1'b1;
    #1;
    total_cnt++; if (o_issue_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0d expected 0", o_issue_valid); else pass_cnt++;
    total_cnt++; if (o_head_pop !== 4'b0000) $display("[TB] FAIL reset_pop: got %0h expected 0", o_head_pop); else pass_cnt++;
    total_cnt++; if (o_issue_wid !== 2'd0 || o_issue_ex_type !== 3'd0) $display("[TB] FAIL reset_wid_ex: got %0d/%0d expected 0/0", o_issue_wid, o_issue_ex_type); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (o_perf_issued !== 32'd0 || o_perf_stalls !== 32'd0) $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", o_perf_issued, o_perf_stalls); else pass_cnt++;
    reset = 1'b0; hv = '0; ir = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [EXB-1:0] e_ex;
    do_reset();
    hv = '1; sb = '1; ur = '1; ir = 1'b1;
    for (int w = 0; w < NW; w++) ext[w*EXB +: EXB] = 3'($urandom_range(0, NEX - 1));
    for (int i = 0; i < 8; i++) begin
      #1;
      e_ex = ext[(i % NW)*EXB +: EXB];
      total_cnt++; if (o_issue_valid !== 1'b1 || o_issue_wid !== 2'(i % NW)) $display("[TB] FAIL rr_wid[%0d]: got v%0d w%0d expected v1 w%0d", i, o_issue_valid, o_issue_wid, i % NW); else pass_cnt++;
      total_cnt++; if (o_head_pop !== 4'(1 << (i % NW)) || o_issue_ex_type !== e_ex) $display("[TB] FAIL rr_pop_ex[%0d]: got %0h/%0d expected %0h/%0d", i, o_head_pop, o_issue_ex_type, 1 << (i % NW), e_ex); else pass_cnt++;
      @(negedge clk);
    end
    #1;
    total_cnt++; if (o_perf_issued !== 32'd8 || o_perf_stalls !== 32'd0) $display("[TB] FAIL rr_counters: got %0d/%0d expected 8/0", o_perf_issued, o_perf_stalls); else pass_cnt++;
  endtask

  task automatic test_lock_hold();
    do_reset();
    hv = 4'b1010; sb = '1; ur = '1; ext = '0; ir = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++; if (o_issue_valid !== 1'b1 || o_issue_wid !== 2'd1 || o_head_pop !== 4'b0000) $display("[TB] FAIL lock_hold[%0d]: got v%0d w%0d p%0h expected v1 w1 p0", c, o_issue_valid, o_issue_wid, o_head_pop); else pass_cnt++;
      @(negedge clk);
    end
    ir = 1'b1;
    #1;
    total_cnt++; if (o_issue_wid !== 2'd1 || o_head_pop !== 4'b0010) $display("[TB] FAIL lock_fire: got w%0d p%0h expected w1 p2", o_issue_wid, o_head_pop); else pass_cnt++;
    @(negedge clk);
    ir = 1'b0;
    #1;
    total_cnt++; if (o_issue_valid !== 1'b1 || o_issue_wid !== 2'd3) $display("[TB] FAIL lock_next: got v%0d w%0d expected v1 w3", o_issue_valid, o_issue_wid); else pass_cnt++;
    total_cnt++; if (o_perf_stalls !== 32'd3 || o_perf_issued !== 32'd1) $display("[TB] FAIL lock_counters: got %0d/%0d expected stalls 3 issued 1", o_perf_stalls, o_perf_issued); else pass_cnt++;
  endtask

  task automatic test_unit_block();
    do_reset();
    hv = 4'b0001; sb = '1; ur = '1; ext = '0; ir = 1'b1;
    #1;
    total_cnt++; if (o_issue_wid !== 2'd0 || o_head_pop !== 4'b0001) $display("[TB] FAIL unit_prime: got w%0d p%0h expected w0 p1", o_issue_wid, o_head_pop); else pass_cnt++;
    @(negedge clk);
    hv = 4'b0101;
    ext = '0; ext[2*EXB +: EXB] = EX_LSU;
    ur = 5'b11101;
    #1;
    total_cnt++; if (o_issue_valid !== 1'b1 || o_issue_wid !== 2'd0 || o_issue_ex_type !== EX_ALU) $display("[TB] FAIL unit_blocked: got v%0d w%0d e%0d expected v1 w0 e0", o_issue_valid, o_issue_wid, o_issue_ex_type); else pass_cnt++;
    @(negedge clk);
    ur = '1;
    #1;
    total_cnt++; if (o_issue_wid !== 2'd2 || o_issue_ex_type !== EX_LSU || o_head_pop !== 4'b0100) $display("[TB] FAIL unit_free: got w%0d e%0d p%0h expected w2 e1 p4", o_issue_wid, o_issue_ex_type, o_head_pop); else pass_cnt++;
    @(negedge clk);
    ir = 1'b0; hv = '0;
  endtask

  task automatic test_sb_stall();
    do_reset();
    hv = '1; sb = '0; ur = '1; ext = '0; ir = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++; if (o_issue_valid !== 1'b0 || o_head_pop !== 4'b0000) $display("[TB] FAIL sb_stall[%0d]: got v%0d p%0h expected v0 p0", c, o_issue_valid, o_head_pop); else pass_cnt++;
      @(negedge clk);
    end
    #1;
    total_cnt++; if (o_perf_stalls !== 32'd5 || o_perf_issued !== 32'd0) $display("[TB] FAIL sb_counters: got %0d/%0d expected 5/0", o_perf_stalls, o_perf_issued); else pass_cnt++;
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    hv = 4'b1000; sb = '1; ur = '1; ext = '0; ir = 1'b0;
    @(negedge clk);
    hv = 4'b1111;
    #1;
    total_cnt++; if (o_issue_valid !== 1'b1 || o_issue_wid !== 2'd3) $display("[TB] FAIL midlock_locked: got v%0d w%0d expected v1 w3", o_issue_valid, o_issue_wid); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (o_issue_valid !== 1'b0 || o_issue_wid !== 2'd0 || o_head_pop !== 4'b0000) $display("[TB] FAIL midlock_reset: got v%0d w%0d p%0h expected 0 0 0", o_issue_valid, o_issue_wid, o_head_pop); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; ir = 1'b1;
    #1;
    total_cnt++; if (o_perf_issued !== 32'd0 || o_perf_stalls !== 32'd0) $display("[TB] FAIL midlock_counters: got %0d/%0d expected 0/0", o_perf_issued, o_perf_stalls); else pass_cnt++;
    total_cnt++; if (o_issue_valid !== 1'b1 || o_issue_wid !== 2'd0) $display("[TB] FAIL midlock_restart: got v%0d w%0d expected v1 w0", o_issue_valid, o_issue_wid); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.r_perf_issued = '1;
    m_issued = '1;
    #1;
    release dut.r_perf_issued;
    #1;
    total_cnt++; if (o_perf_issued !== 32'hFFFF_FFFF) $display("[TB] FAIL wrap_preload: got %0h expected ffffffff", o_perf_issued); else pass_cnt++;
    hv = 4'b0001; sb = '1; ur = '1; ext = '0; ir = 1'b1;
    @(negedge clk);
    hv = '0; ir = 1'b0;
    #1;
    total_cnt++; if (o_perf_issued !== 32'd0) $display("[TB] FAIL wrap_issued: got %0h expected 0", o_perf_issued); else pass_cnt++;
  endtask

  task automatic test_random();
    int             win;
    bit             e_valid;
    logic [1:0]     e_wid;
    logic [EXB-1:0] e_ex;
    logic [NW-1:0]  e_pop;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      for (int w = 0; w < NW; w++) begin
        if (!(m_locked && w == m_lock)) begin
          hv[w] = ($urandom_range(0, 3) != 0);
          sb[w] = ($urandom_range(0, 3) != 0);
          ext[w*EXB +: EXB] = 3'($urandom_range(0, 7));
        end
      end
      ur = 5'($urandom);
      ir = ($urandom_range(0, 2) != 0);
      #1;
      win     = reset ? -1 : m_winner();
      e_valid = (win >= 0);
      e_wid   = e_valid ? 2'(win) : 2'd0;
      e_ex    = e_valid ? ext[win*EXB +: EXB] : 3'd0;
      e_pop   = (e_valid && ir) ? 4'(1 << win) : 4'd0;
      total_cnt++; if (o_issue_valid !== e_valid || o_issue_wid !== e_wid) $display("[TB] FAIL rand_sel[%0d]: got v%0d w%0d expected v%0d w%0d", c, o_issue_valid, o_issue_wid, e_valid, e_wid); else pass_cnt++;
      total_cnt++; if (o_issue_ex_type !== e_ex || o_head_pop !== e_pop) $display("[TB] FAIL rand_ex_pop[%0d]: got e%0d p%0h expected e%0d p%0h", c, o_issue_ex_type, o_head_pop, e_ex, e_pop); else pass_cnt++;
      total_cnt++; if (o_perf_issued !== m_issued || o_perf_stalls !== m_stalls) $display("[TB] FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d", c, o_perf_issued, o_perf_stalls, m_issued, m_stalls); else pass_cnt++;
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hv = '0; sb = '0; ur = '0; ext = '0; ir = 1'b0;
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_unit_block();
    test_sb_stall();
    test_reset_mid_lock();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vx_issue_sched.md
Name: vx_issue_sched

Overview:
- Per-cycle warp issue scheduler in front of the dispatch stage.
- Picks one warp among `NUM_WARPS` instruction-buffer heads that are valid, scoreboard-clear, and whose target execute unit (ALU/LSU/CSR/FPU/GPU) can accept.
- Presents the chosen warp on a valid/ready interface to dispatch.
- Fair round-robin selection, winner locked while stalled, stall/issue performance counters.

Parameters:
- NUM_WARPS, 4, number of warps / ibuffer heads; power of two, 2..32
- EX_BITS, 3, width of the ex_type encoding
- NUM_EX, 5, number of execute units; ex_type values 0..NUM_EX-1 (ALU=0, LSU=1, CSR=2, FPU=3, GPU=4)
- PERF_W, 32, performance counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- head_valid  in  NUM_WARPS  per-warp ibuffer head holds an instruction
- head_ex_type  in  NUM_WARPS*EX_BITS  per-warp ex_type of head instruction, warp w at [w*EX_BITS +: EX_BITS]
- sb_ready  in  NUM_WARPS  per-warp scoreboard: all source/dest registers free
- unit_ready  in  NUM_EX  per-unit dispatch buffer can accept this cycle
- head_pop  out  NUM_WARPS  one-hot; pops the granted warp's ibuffer head on issue
- issue_valid  out  1  an instruction is presented to dispatch
- issue_wid  out  log2(NUM_WARPS)  selected warp id
- issue_ex_type  out  EX_BITS  ex_type of the selected instruction
- issue_ready  in  1  dispatch accepts
- perf_issued  out  PERF_W  instructions issued since reset
- perf_stalls  out  PERF_W  cycles with at least one head_valid but no issue

Behaviour:
- Eligible[w] = head_valid[w] & sb_ready[w] & unit_ready[ex(w)].
  - ex(w) >= NUM_EX counts as unit ready (NOP, mirrors dispatch default).
- Fire = issue_valid & issue_ready. head_pop = onehot(issue_wid) & {NUM_WARPS{fire}}.
- Output path is combinational from inputs plus registered state. Zero-cycle latency: an eligible warp in cycle N may fire in cycle N.
- State:
  - rr_ptr: log2(NUM_WARPS) bits, reset 0.
  - lock_valid: reset 0.
  - lock_wid: reset 0.
- Two-state FSM:
  - IDLE (lock_valid=0):
    - Winner = first eligible warp scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_WARPS.
    - issue_valid = |eligible. issue_wid = winner. issue_ex_type = head_ex_type[winner].
    - On fire: rr_ptr <= winner+1 (wraps), stay IDLE.
    - On issue_valid & ~issue_ready: lock_wid <= winner, go LOCKED.
  - LOCKED (lock_valid=1):
    - issue_valid = 1, issue_wid = lock_wid, regardless of the eligibility of other warps.
    - Stability rule: wid and ex_type do not change until fire.
    - On fire: rr_ptr <= lock_wid+1, go IDLE.
    - Upstream holds head_valid/sb_ready for a locked warp. A deasserted head_valid[lock_wid] while locked is a protocol error; flag it with an assertion only, no recovery.
- Counters:
  - perf_issued += 1 on fire.
  - perf_stalls += 1 when (|head_valid) & ~fire.
  - Both wrap modulo 2^PERF_W. Reset 0.
- Reset values:
  - All outputs 0: issue_valid=0, head_pop=0, issue_wid=0, issue_ex_type=0, counters 0.
  - Reset mid-lock discards the lock. The next cycle starts from IDLE with rr_ptr=0.
- Boundaries:
  - No eligible warp: issue_valid=0, head_pop=0.
  - Single eligible warp: wins every cycle it is eligible.
  - rr_ptr = NUM_WARPS-1 and the winner is that warp: rr_ptr wraps to 0.
  - unit_ready dropping for a locked warp's unit does not unlock it. Dispatch owns back-pressure through issue_ready.
- X-free: no output depends on head_ex_type of a non-selected warp.

Decomposition:
- Shared package:
  - EX_* unit encodings and EX_BITS/NUM_EX constants, shared with dispatch and decode.
  - issue_state_e {IDLE, LOCKED}.
  - PERF_W default.
- One sub-module, vx_rr_pick: combinational rotate-priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: grant index, grant valid.
  - Reusable by the commit arbiter.

Test Plan:
- All 4 warps eligible, issue_ready=1 for 8 cycles -> issue_wid sequence 0,1,2,3,0,1,2,3. perf_issued=8, perf_stalls=0.
- Warps 1 and 3 eligible, issue_ready=0 for 3 cycles, then 1 -> issue_wid=1 held 4 cycles, one head_pop=0b0010. Next grant is 3. perf_stalls=3.
- Warp 2 head is LSU with unit_ready[LSU]=0, warp 0 is ALU ready, rr_ptr=1 -> warp 0 issues. Warp 2 issues the first cycle unit_ready[LSU]=1.
- sb_ready=0b0000 with head_valid=0b1111 for 5 cycles -> issue_valid=0 throughout, perf_stalls increments to 5.
- Lock on warp 3, then assert reset 1 cycle -> outputs 0. After reset with all warps eligible, first issue_wid=0.
- Preload perf_issued to 2^32-1 via force, one fire -> perf_issued=0.
